// File: rtl/tod_clock_core.sv
// Time-of-day counter driven from the system clock through a prescaler.
// Time is stored in 24 h form. disp_hours and pm are a purely combinational
// 12/24 h view of that stored time.
// Optional alarm: define TOD_ALARM_EN to add the alarm ports and logic.
module tod_clock_core #(
  parameter int unsigned TICK_DIV  = 100000000,
  parameter int unsigned PRE_W     = 27
`ifdef TOD_ALARM_EN
  ,
  parameter int unsigned ALARM_LEN = 60
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode,
  input  logic       run,
  input  logic       set_valid,
  input  logic [4:0] set_hours,
  input  logic [5:0] set_minutes,
  input  logic [5:0] set_seconds,
  output logic       set_err,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [4:0] hours,
  output logic [4:0] disp_hours,
  output logic       pm,
  output logic       tick,
`ifdef TOD_ALARM_EN
  input  logic       alarm_set,
  input  logic [4:0] alarm_hours,
  input  logic [5:0] alarm_minutes,
  input  logic       alarm_arm,
  input  logic       alarm_ack,
  output logic       alarm,
`endif
  output logic       day_wrap
);

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre_q;
  logic [5:0]       sec_q, min_q;
  logic [4:0]       hr_q;
  logic             tick_q, wrap_q, err_q;

  logic [5:0]       nxt_sec, nxt_min;
  logic [4:0]       nxt_hr;
  logic             nxt_wrap;
  logic             load_ok, load_now, tick_now, alarm_bad;

  assign load_ok  = (set_hours < 5'd24) && (set_minutes < 6'd60) && (set_seconds < 6'd60);
  assign load_now = set_valid && load_ok;
  assign tick_now = run && (pre_q == PRE_MAX);

  // Incremented time with all carries resolved in one step
  always_comb begin
    nxt_sec  = sec_q + 6'd1;
    nxt_min  = min_q;
    nxt_hr   = hr_q;
    nxt_wrap = 1'b0;
    if (sec_q == 6'd59) begin
      nxt_sec = '0;
      nxt_min = min_q + 6'd1;
      if (min_q == 6'd59) begin
        nxt_min = '0;
        nxt_hr  = hr_q + 5'd1;
        if (hr_q == 5'd23) begin
          nxt_hr   = '0;
          nxt_wrap = 1'b1;
        end
      end
    end
  end

  // Prescaler, time registers and pulse outputs; a valid load beats a tick
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q  <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hr_q   <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else if (load_now) begin
      pre_q  <= '0;
      sec_q  <= set_seconds;
      min_q  <= set_minutes;
      hr_q   <= set_hours;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else if (tick_now) begin
      pre_q  <= '0;
      sec_q  <= nxt_sec;
      min_q  <= nxt_min;
      hr_q   <= nxt_hr;
      tick_q <= 1'b1;
      wrap_q <= nxt_wrap;
    end else begin
      if (run) begin
        pre_q <= pre_q + PRE_W'(1);
      end
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end
  end

  // Rejected time or alarm loads raise a single-cycle error pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (set_valid && !load_ok) || alarm_bad;
    end
  end

  // 12/24 h display view of the stored 24 h time
  always_comb begin
    disp_hours = hr_q;
    if (mode) begin
      if (hr_q == 5'd0) begin
        disp_hours = 5'd12;
      end else if (hr_q > 5'd12) begin
        disp_hours = hr_q - 5'd12;
      end
    end
  end

  assign pm       = (hr_q >= 5'd12);
  assign seconds  = sec_q;
  assign minutes  = min_q;
  assign hours    = hr_q;
  assign tick     = tick_q;
  assign day_wrap = wrap_q;
  assign set_err  = err_q;

`ifdef TOD_ALARM_EN
  localparam logic [7:0] ALARM_TICKS = 8'(ALARM_LEN);

  logic [4:0] al_hr_q;
  logic [5:0] al_min_q;
  logic [7:0] al_cnt_q;
  logic       alarm_q;
  logic       alarm_ok, match;

  assign alarm_ok  = (alarm_hours < 5'd24) && (alarm_minutes < 6'd60);
  assign alarm_bad = alarm_set && !alarm_ok;
  // Only a real tick can trigger; a load landing on the alarm time does not
  assign match     = (nxt_sec == 6'd0) && (nxt_min == al_min_q) && (nxt_hr == al_hr_q);

  // Alarm setting, trigger and timed/acknowledged release
  always_ff @(posedge clk) begin
    if (reset) begin
      al_hr_q  <= '0;
      al_min_q <= '0;
      al_cnt_q <= '0;
      alarm_q  <= 1'b0;
    end else begin
      if (alarm_set && alarm_ok) begin
        al_hr_q  <= alarm_hours;
        al_min_q <= alarm_minutes;
      end
      if (alarm_ack || !alarm_arm) begin
        alarm_q  <= 1'b0;
        al_cnt_q <= '0;
      end else if (tick_now && !load_now) begin
        if (match) begin
          alarm_q  <= 1'b1;
          al_cnt_q <= ALARM_TICKS;
        end else if (alarm_q) begin
          if (al_cnt_q == 8'd1) begin
            alarm_q  <= 1'b0;
            al_cnt_q <= '0;
          end else begin
            al_cnt_q <= al_cnt_q - 8'd1;
          end
        end
      end
    end
  end

  assign alarm = alarm_q;
`else
  assign alarm_bad = 1'b0;
`endif

endmodule

// File: tb/tb_tod_clock_core.sv
// Directed bench for tod_clock_core with TICK_DIV=4 (PRE_W=3).
// Alarm cases are built only when TOD_ALARM_EN is defined (ALARM_LEN=3).
module tb_tod_clock_core;

  logic       clk = 1'b0;
  logic       reset, mode, run, set_valid;
  logic [4:0] set_hours;
  logic [5:0] set_minutes, set_seconds;
  logic       set_err, pm, tick, day_wrap;
  logic [5:0] seconds, minutes;
  logic [4:0] hours, disp_hours;
`ifdef TOD_ALARM_EN
  logic       alarm_set, alarm_arm, alarm_ack, alarm;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  tod_clock_core #(
    .TICK_DIV (4),
    .PRE_W    (3)
`ifdef TOD_ALARM_EN
    ,
    .ALARM_LEN(3)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .run        (run),
    .set_valid  (set_valid),
    .set_hours  (set_hours),
    .set_minutes(set_minutes),
    .set_seconds(set_seconds),
    .set_err    (set_err),
    .seconds    (seconds),
    .minutes    (minutes),
    .hours      (hours),
    .disp_hours (disp_hours),
    .pm         (pm),
    .tick       (tick),
`ifdef TOD_ALARM_EN
    .alarm_set    (alarm_set),
    .alarm_hours  (alarm_hours),
    .alarm_minutes(alarm_minutes),
    .alarm_arm    (alarm_arm),
    .alarm_ack    (alarm_ack),
    .alarm        (alarm),
`endif
    .day_wrap   (day_wrap)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    set_valid   = 1'b1;
    set_hours   = h;
    set_minutes = m;
    set_seconds = s;
    cyc();
    set_valid   = 1'b0;
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, ".h"}, 32'(hours), 32'(h));
    check({tag, ".m"}, 32'(minutes), 32'(m));
    check({tag, ".s"}, 32'(seconds), 32'(s));
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; run = 1'b0; set_valid = 1'b0;
    set_hours = '0; set_minutes = '0; set_seconds = '0;
`ifdef TOD_ALARM_EN
    alarm_set = 1'b0; alarm_arm = 1'b0; alarm_ack = 1'b0;
    alarm_hours = '0; alarm_minutes = '0;
`endif
    cyc(); cyc();

    // Reset state
    check_time("rst", 0, 0, 0);
    check("rst.tick", 32'(tick), 0);
    check("rst.wrap", 32'(day_wrap), 0);
    check("rst.err", 32'(set_err), 0);
    check("rst.disp24", 32'(disp_hours), 0);
    check("rst.pm", 32'(pm), 0);
    mode = 1'b1; #1;
    check("rst.disp12", 32'(disp_hours), 12);
    mode = 1'b0;
`ifdef TOD_ALARM_EN
    check("rst.alarm", 32'(alarm), 0);
`endif

    // Free run 16 clocks: ticks on clocks 4, 8, 12, 16
    reset = 1'b0; run = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      check($sformatf("run.tick%0d", i), 32'(tick), (i % 4 == 0) ? 1 : 0);
    end
    check_time("run16", 0, 0, 4);

    // Day wrap
    load(5'd23, 6'd59, 6'd58);
    check_time("ld235958", 23, 59, 58);
    check("ld.tick", 32'(tick), 0);
    for (int i = 1; i <= 8; i++) begin
      cyc();
      check($sformatf("dw.tick%0d", i), 32'(tick), (i % 4 == 0) ? 1 : 0);
      check($sformatf("dw.wrap%0d", i), 32'(day_wrap), (i == 8) ? 1 : 0);
      if (i == 4) check_time("dw.59", 23, 59, 59);
    end
    check_time("dw.00", 0, 0, 0);

    // Display modes
    run = 1'b0;
    load(5'd13, 6'd5, 6'd0);
    check("d13.m0", 32'(disp_hours), 13);
    mode = 1'b1; #1;
    check("d13.m1", 32'(disp_hours), 1);
    check("d13.pm", 32'(pm), 1);
    mode = 1'b0; #1;
    check("d13.m0b", 32'(disp_hours), 13);
    check("d13.pm0", 32'(pm), 1);
    mode = 1'b1;
    load(5'd0, 6'd0, 6'd0);
    check("d00.m1", 32'(disp_hours), 12);
    check("d00.pm", 32'(pm), 0);
    load(5'd12, 6'd0, 6'd0);
    check("d12.m1", 32'(disp_hours), 12);
    check("d12.pm", 32'(pm), 1);
    mode = 1'b0;

    // Rejected loads
    load(5'd10, 6'd20, 6'd30);
    load(5'd24, 6'd0, 6'd0);
    check("bad24.err", 32'(set_err), 1);
    check_time("bad24", 10, 20, 30);
    cyc();
    check("bad24.err_off", 32'(set_err), 0);
    load(5'd10, 6'd60, 6'd0);
    check("bad60.err", 32'(set_err), 1);
    check_time("bad60", 10, 20, 30);
    cyc();
    check("bad60.err_off", 32'(set_err), 0);

    // Rejected load on a tick cycle: tick still happens
    run = 1'b1;
    cyc(); cyc(); cyc();
    load(5'd24, 6'd0, 6'd0);
    check("badtk.err", 32'(set_err), 1);
    check("badtk.tick", 32'(tick), 1);
    check_time("badtk", 10, 20, 31);

    // Valid load on a tick cycle: tick discarded
    cyc(); cyc(); cyc();
    load(5'd5, 6'd6, 6'd7);
    check("ldtk.tick", 32'(tick), 0);
    check("ldtk.err", 32'(set_err), 0);
    check_time("ldtk", 5, 6, 7);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check($sformatf("ldtk.tick%0d", i), 32'(tick), (i == 4) ? 1 : 0);
    end
    check_time("ldtk.next", 5, 6, 8);

    // Pause mid-count freezes prescaler and time
    cyc(); cyc();
    run = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      check($sformatf("pause.tick%0d", i), 32'(tick), 0);
    end
    check_time("pause", 5, 6, 8);
    run = 1'b1;
    cyc();
    check("resume.tick1", 32'(tick), 0);
    cyc();
    check("resume.tick2", 32'(tick), 1);
    check_time("resume", 5, 6, 9);

    // Load while paused
    run = 1'b0;
    load(5'd1, 6'd2, 6'd3);
    check_time("pld", 1, 2, 3);
    for (int i = 0; i < 5; i++) cyc();
    check_time("pld.hold", 1, 2, 3);

    // Reset mid-count
    run = 1'b1;
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    check_time("mrst", 0, 0, 0);
    check("mrst.tick", 32'(tick), 0);
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check($sformatf("mrst.tick%0d", i), 32'(tick), (i == 4) ? 1 : 0);
    end
    check_time("mrst.next", 0, 0, 1);

`ifdef TOD_ALARM_EN
    // Alarm at 06:30, ALARM_LEN = 3
    run = 1'b0;
    alarm_set = 1'b1; alarm_hours = 5'd6; alarm_minutes = 6'd30;
    cyc();
    alarm_set = 1'b0;
    check("aset.err", 32'(set_err), 0);
    alarm_set = 1'b1; alarm_hours = 5'd24; alarm_minutes = 6'd0;
    cyc();
    alarm_set = 1'b0;
    check("abad.err", 32'(set_err), 1);
    alarm_arm = 1'b1;
    load(5'd6, 6'd29, 6'd59);
    run = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      check($sformatf("al.%0d", i), 32'(alarm), (i >= 4 && i < 16) ? 1 : 0);
    end

    // Acknowledge after one tick
    run = 1'b0;
    load(5'd6, 6'd29, 6'd59);
    run = 1'b1;
    for (int i = 1; i <= 8; i++) cyc();
    check("ack.before", 32'(alarm), 1);
    alarm_ack = 1'b1;
    cyc();
    alarm_ack = 1'b0;
    check("ack.after", 32'(alarm), 0);

    // Load landing on the alarm time does not trigger
    run = 1'b0;
    load(5'd6, 6'd30, 6'd0);
    cyc();
    check("ldmatch", 32'(alarm), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
